n_bit_universal_register: RTL and testbench

Parametrised successor to the plain N-bit D register. It adds a clock enable, parallel load, logical/arithmetic shifts, rotates and synchronous clear, all selected by a mode field. It provides a serial shift-out bit and a zero flag. It is used as the general-purpose storage/shift element in lab datapaths such as serial converters, multipliers and LFSR-style experiments.

---
 rtl/n_bit_universal_register.sv | 86 ++++++++
 tb/tb_n_bit_universal_register.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/n_bit_universal_register.sv
// n-bit universal register: hold, parallel load, logical shifts, rotates,
// arithmetic shift right and synchronous clear, chosen by a 3-bit mode.
// shout keeps the last bit shifted or rotated out; zero flags Q == 0.
module n_bit_universal_register #(
    parameter int             n         = 8,
    parameter logic [n-1:0]   RESET_VAL = {n{1'b0}}
) (
    input  logic         clk,
    input  logic         Resetn,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [n-1:0] D,
    input  logic         sin_l,
    input  logic         sin_r,
    output logic [n-1:0] Q,
    output logic         shout,
    output logic         zero
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [n-1:0] q_q, q_d;
    logic         shout_q, shout_d;

    // Next-state decode; en=0 falls through to hold for every mode.
    always_comb begin
        q_d     = q_q;
        shout_d = shout_q;
        if (en) begin
            unique case (mode)
                M_HOLD: ;
                M_LOAD: q_d = D;
                M_SHL: begin
                    q_d     = {q_q[n-2:0], sin_l};
                    shout_d = q_q[n-1];
                end
                M_SHR: begin
                    q_d     = {sin_r, q_q[n-1:1]};
                    shout_d = q_q[0];
                end
                M_ROL: begin
                    q_d     = {q_q[n-2:0], q_q[n-1]};
                    shout_d = q_q[n-1];
                end
                M_ROR: begin
                    q_d     = {q_q[0], q_q[n-1:1]};
                    shout_d = q_q[0];
                end
                M_ASR: begin
                    // sign bit replicated; sin_r deliberately unused here
                    q_d     = {q_q[n-1], q_q[n-1:1]};
                    shout_d = q_q[0];
                end
                M_CLR: begin
                    // clear goes to zero, not to RESET_VAL
                    q_d     = '0;
                    shout_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State register; reset is asynchronous and dominates everything.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            q_q     <= RESET_VAL;
            shout_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            shout_q <= shout_d;
        end
    end

    assign Q     = q_q;
    assign shout = shout_q;
    assign zero  = (q_q == '0);

endmodule

// File: tb/tb_n_bit_universal_register.sv
// Scoreboard bench for n_bit_universal_register at n=5: each operation pushes
// its expected Q/shout, the entry is popped and compared after the edge.
module tb_n_bit_universal_register;

    localparam int N = 5;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

    logic         clk, Resetn, en, sin_l, sin_r;
    logic [2:0]   mode;
    logic [N-1:0] D, Q;
    logic         shout, zero;

    typedef struct {
        string        tag;
        logic [N-1:0] q;
        logic         sh;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    n_bit_universal_register #(.n(N), .RESET_VAL('0)) dut (
        .clk(clk), .Resetn(Resetn), .en(en), .mode(mode), .D(D),
        .sin_l(sin_l), .sin_r(sin_r), .Q(Q), .shout(shout), .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one operation, queue its expectation, compare after the edge.
    task automatic op(input string tag, input logic e, input logic [2:0] m,
                      input logic [N-1:0] d, input logic sl, input logic sr,
                      input logic [N-1:0] eq, input logic es);
        exp_t x;
        exp_t y;
        en = e; mode = m; D = d; sin_l = sl; sin_r = sr;
        x.tag = tag; x.q = eq; x.sh = es;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            y = sb.pop_front();
            chk({y.tag, "_q"},     32'(Q),     32'(y.q));
            chk({y.tag, "_shout"}, 32'(shout), 32'(y.sh));
            chk({y.tag, "_zero"},  32'(zero),  32'(y.q == '0));
        end
    endtask

    // Independent reference for the random section.
    task automatic model(input logic e, input logic [2:0] m, input logic [N-1:0] d,
                         input logic sl, input logic sr,
                         inout logic [N-1:0] q, inout logic s);
        logic [N-1:0] pq;
        pq = q;
        if (e) begin
            case (m)
                LOAD: q = d;
                SHL:  begin q = (pq << 1) | N'(sl);                    s = pq[N-1]; end
                SHR:  begin q = (pq >> 1) | (N'(sr) << (N-1));         s = pq[0];   end
                ROL:  begin q = (pq << 1) | N'(pq[N-1]);               s = pq[N-1]; end
                ROR:  begin q = (pq >> 1) | (N'(pq[0]) << (N-1));      s = pq[0];   end
                ASR:  begin q = (pq >> 1) | (N'(pq[N-1]) << (N-1));    s = pq[0];   end
                CLR:  begin q = '0; s = 1'b0; end
                default: ;
            endcase
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] mq;
        logic         ms;
        logic [N-1:0] rd;
        logic [2:0]   rm;
        logic         re, rl, rr;

        // reset held low across edges with LOAD requested
        Resetn = 1'b0; en = 1'b1; mode = LOAD; D = 5'b10110; sin_l = 1'b0; sin_r = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_shout", 32'(shout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        Resetn = 1'b1;

        op("rel_load", 1, LOAD, 5'b10110, 0, 0, 5'b10110, 0);
        op("shl",      1, SHL,  5'b00000, 1, 0, 5'b01101, 1);
        op("shr",      1, SHR,  5'b00000, 0, 0, 5'b00110, 1);
        op("hold",     1, HOLD, 5'b11111, 1, 1, 5'b00110, 1);
        op("ld01101",  1, LOAD, 5'b01101, 0, 0, 5'b01101, 1);
        op("ror",      1, ROR,  5'b00000, 0, 0, 5'b10110, 1);
        op("rol1",     1, ROL,  5'b00000, 0, 0, 5'b01101, 1);
        op("rol2",     1, ROL,  5'b00000, 0, 0, 5'b11010, 0);
        op("rol3",     1, ROL,  5'b00000, 0, 0, 5'b10101, 1);
        op("rol4",     1, ROL,  5'b00000, 0, 0, 5'b01011, 1);
        op("rol5",     1, ROL,  5'b00000, 0, 0, 5'b10110, 0);
        op("asr1",     1, ASR,  5'b00000, 1, 0, 5'b11011, 0);
        op("asr2",     1, ASR,  5'b00000, 1, 0, 5'b11101, 1);
        op("ld10101",  1, LOAD, 5'b10101, 0, 0, 5'b10101, 1);
        op("en0_a",    0, LOAD, 5'b01010, 0, 0, 5'b10101, 1);
        op("en0_b",    0, LOAD, 5'b01010, 0, 0, 5'b10101, 1);
        op("en0_shl",  0, SHL,  5'b00000, 0, 0, 5'b10101, 1);
        op("clr",      1, CLR,  5'b01010, 0, 0, 5'b00000, 0);
        op("shr_sin1", 1, SHR,  5'b00000, 0, 1, 5'b10000, 0);

        // async reset 7 ns after an edge
        op("ld11111",  1, LOAD, 5'b11111, 0, 0, 5'b11111, 0);
        op("shl_11111",1, SHL,  5'b00000, 1, 0, 5'b11111, 1);
        #6 Resetn = 1'b0;
        #1;
        chk("async_q", 32'(Q), 32'd0);
        chk("async_shout", 32'(shout), 32'd0);
        chk("async_zero", 32'(zero), 32'd1);
        @(posedge clk); #1;
        chk("async_edge_q", 32'(Q), 32'd0);
        @(negedge clk);
        Resetn = 1'b1;

        // random section against the reference model
        mq = '0; ms = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd = N'($urandom);
            rm = 3'($urandom_range(0, 7));
            re = ($urandom_range(0, 7) != 0);
            rl = 1'($urandom);
            rr = 1'($urandom);
            model(re, rm, rd, rl, rr, mq, ms);
            op($sformatf("rnd%0d", i), re, rm, rd, rl, rr, mq, ms);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
